// File: rtl/sram_port_arbiter_pkg.sv
// Shared constants and request record for the fetch/data SRAM arbiter.
package mips_mem_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_HI   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  localparam logic STB_ON  = 1'b0;
  localparam logic STB_OFF = 1'b1;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_req_t;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// Core-side request/response bundle: fetch port and load/store port.
interface sram_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    output if_rdata, if_ack, d_rdata, d_ack
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be,
    input  if_rdata, if_ack, d_rdata, d_ack
  );
endinterface

// File: rtl/sram_port_arbiter_rr_arbiter2.sv
// Two-way round-robin: on contention the port that did not win last time wins.
module rr_arbiter2
  import mips_mem_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_vld,
  output logic       gnt_port
);
  always_comb begin
    gnt_vld  = |req;
    gnt_port = req[1] ? PORT_DATA : PORT_FETCH;
    if (&req) gnt_port = ~last_grant;
  end
endmodule

// File: rtl/sram_port_arbiter.sv
// Splits 32-bit fetch/data word requests into one or two 16-bit async SRAM cycles.
module sram_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = 0,
  parameter int ADDR_W      = 18
) (
  input  logic              clock,
  input  logic              reset,
  sram_port_arbiter_if.slave cpu,
  output logic [ADDR_W-1:0] addr,
  inout  wire  [15:0]       data,
  output logic              wre,
  output logic              oute,
  output logic              chip_en,
  output logic              hb_mask,
  output logic              lb_mask
);
  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WMAX = CW'(WAIT_CYCLES);

  logic [1:0]    state, nxt;
  logic [CW-1:0] wcnt;
  logic          last_grant, gnt_vld, gnt_port;
  logic          lo_on, hi_on, phase_end, hsel;
  logic [15:0]   lo_buf, dout;
  mem_req_t      cur_r, cur;
  logic          unused_addr;

  rr_arbiter2 u_rr (
    .req        ({cpu.d_req, cpu.if_req}),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt_port   (gnt_port)
  );

  // In IDLE the request is taken straight from the ports so the first phase
  // can be registered on the same edge that latches it.
  always_comb begin
    cur = cur_r;
    if (state == S_IDLE) begin
      cur.port  = gnt_port;
      cur.we    = (gnt_port == PORT_DATA) & cpu.d_we;
      cur.addr  = (gnt_port == PORT_DATA) ? cpu.d_addr : cpu.if_addr;
      cur.wdata = cpu.d_wdata;
      cur.be    = (gnt_port == PORT_DATA) ? cpu.d_be : 4'hF;
    end
  end

  assign unused_addr = ^{cur.addr[31:ADDR_W+1], cur.addr[1:0]};
  assign lo_on     = !cur.we || (|cur.be[1:0]);
  assign hi_on     = !cur.we || (|cur.be[3:2]);
  assign phase_end = (wcnt == WMAX);
  assign hsel      = (nxt == S_HI) ? HALF_HI : HALF_LO;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: if (gnt_vld) nxt = lo_on ? S_LO : (hi_on ? S_HI : S_DONE);
      S_LO:   if (phase_end) nxt = hi_on ? S_HI : S_DONE;
      S_HI:   if (phase_end) nxt = S_DONE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      wcnt         <= '0;
      last_grant   <= PORT_FETCH;
      cur_r        <= '0;
      lo_buf       <= '0;
      dout         <= '0;
      addr         <= '0;
      chip_en      <= STB_OFF;
      wre          <= STB_OFF;
      oute         <= STB_OFF;
      hb_mask      <= STB_OFF;
      lb_mask      <= STB_OFF;
      cpu.if_ack   <= 1'b0;
      cpu.d_ack    <= 1'b0;
      cpu.if_rdata <= '0;
      cpu.d_rdata  <= '0;
    end else begin
      state      <= nxt;
      wcnt       <= (nxt != state) ? '0 : wcnt + 1'b1;
      cpu.if_ack <= 1'b0;
      cpu.d_ack  <= 1'b0;
      if (state == S_IDLE && gnt_vld) cur_r <= cur;
      if (state == S_LO && phase_end && !cur.we) lo_buf <= data;
      // Reads always reach DONE from the last HI cycle, so the bus holds the upper half now.
      if (nxt == S_DONE && state != S_DONE) begin
        last_grant <= cur.port;
        if (cur.port == PORT_DATA) begin
          cpu.d_ack <= 1'b1;
          if (!cur.we) cpu.d_rdata <= {data, lo_buf};
        end else begin
          cpu.if_ack <= 1'b1;
          if (!cur.we) cpu.if_rdata <= {data, lo_buf};
        end
      end
      if (nxt == S_LO || nxt == S_HI) begin
        chip_en <= STB_ON;
        addr    <= {cur.addr[ADDR_W:2], hsel};
        if (cur.we) begin
          wre     <= STB_ON;
          oute    <= STB_OFF;
          lb_mask <= hsel ? ~cur.be[2] : ~cur.be[0];
          hb_mask <= hsel ? ~cur.be[3] : ~cur.be[1];
          dout    <= hsel ? cur.wdata[31:16] : cur.wdata[15:0];
        end else begin
          wre     <= STB_OFF;
          oute    <= STB_ON;
          lb_mask <= STB_ON;
          hb_mask <= STB_ON;
        end
      end else begin
        chip_en <= STB_OFF;
        wre     <= STB_OFF;
        oute    <= STB_OFF;
        lb_mask <= STB_OFF;
        hb_mask <= STB_OFF;
      end
    end
  end

  assign data = (wre == STB_ON) ? dout : 16'hzzzz;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Randomized fetch/data traffic against a transaction-level schedule model, plus directed cases.
module tb_sram_port_arbiter;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_n  = 1'b1;
  logic rst2_n = 1'b1;
  sram_port_arbiter_if bus0 ();
  sram_port_arbiter_if bus1 ();

  logic [17:0] addr0, addr1;
  wire  [15:0] data0, data1;
  logic wre0, oe0, ce0, hb0, lb0;
  logic wre1, oe1, ce1, hb1, lb1;

  sram_port_arbiter #(.WAIT_CYCLES(0), .ADDR_W(18)) dut0 (
    .clock(clock), .reset(rst_n), .cpu(bus0), .addr(addr0), .data(data0),
    .wre(wre0), .oute(oe0), .chip_en(ce0), .hb_mask(hb0), .lb_mask(lb0));

  sram_port_arbiter #(.WAIT_CYCLES(2), .ADDR_W(18)) dut1 (
    .clock(clock), .reset(rst2_n), .cpu(bus1), .addr(addr1), .data(data1),
    .wre(wre1), .oute(oe1), .chip_en(ce1), .hb_mask(hb1), .lb_mask(lb1));

  logic [15:0] sram    [0:262143];
  logic [15:0] ref_mem [0:262143];

  assign data0 = (!ce0 && !oe0 && wre0) ? sram[addr0] : 16'hzzzz;
  assign data1 = (!ce1 && !oe1 && wre1) ? (addr1[15:0] ^ 16'h5A5A) : 16'hzzzz;

  always @(posedge clock) begin
    if (!ce0 && !wre0) begin
      if (!lb0) sram[addr0][7:0]  <= data0[7:0];
      if (!hb0) sram[addr0][15:8] <= data0[15:8];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One expected cycle of dut0 outputs.
  typedef struct {
    logic        ce, wen, oen, lb, hb;
    logic [17:0] a;
    logic [15:0] wd;
    logic        ia, da;
    logic [31:0] ir, dr;
    bit          done;
  } exp_t;

  exp_t        q[$];
  logic [31:0] held_ir, held_dr;
  bit          last_p, act, act_port;

  // Schedule model: on each grant, lay out the whole transaction cycle by cycle.
  task automatic schedule();
    bit          fr, dq, p, we, on;
    logic [31:0] a, wd;
    logic [3:0]  be;
    logic [16:0] hw;
    exp_t        e;
    fr = bus0.if_req;
    dq = bus0.d_req;
    if (!(fr || dq)) return;
    p  = (fr && dq) ? !last_p : dq;
    we = p & bus0.d_we;
    a  = p ? bus0.d_addr : bus0.if_addr;
    be = p ? bus0.d_be : 4'hF;
    wd = bus0.d_wdata;
    hw = a[18:2];
    for (int h = 0; h < 2; h++) begin
      on = !we || be[2*h] || be[2*h+1];
      if (on) begin
        e.ce = 1'b0; e.a = {hw, h[0]}; e.wd = h ? wd[31:16] : wd[15:0];
        e.wen = !we; e.oen = we;
        e.lb = we ? !be[2*h] : 1'b0; e.hb = we ? !be[2*h+1] : 1'b0;
        e.ia = 1'b0; e.da = 1'b0; e.ir = held_ir; e.dr = held_dr; e.done = 0;
        q.push_back(e);
      end
    end
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) begin
          if (b % 2 == 0) ref_mem[{hw, b[1]}][7:0]  = wd[8*b +: 8];
          else            ref_mem[{hw, b[1]}][15:8] = wd[8*b +: 8];
        end
    end else if (p) held_dr = {ref_mem[{hw, 1'b1}], ref_mem[{hw, 1'b0}]};
    else            held_ir = {ref_mem[{hw, 1'b1}], ref_mem[{hw, 1'b0}]};
    e = '{ce: 1'b1, wen: 1'b1, oen: 1'b1, lb: 1'b1, hb: 1'b1, a: '0, wd: '0,
          ia: !p, da: p, ir: held_ir, dr: held_dr, done: 1};
    q.push_back(e);
    last_p   = p;
    act      = 1;
    act_port = p;
  endtask

  always @(negedge clock) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
      held_ir = '0; held_dr = '0; last_p = 0; act = 0;
      chk("rst_strobes", {ce0, wre0, oe0, hb0, lb0}, 32'h1F);
      chk("rst_acks", {bus0.if_ack, bus0.d_ack}, 32'h0);
      chk("rst_if_rdata", bus0.if_rdata, 32'h0);
      chk("rst_d_rdata", bus0.d_rdata, 32'h0);
      chk("rst_addr", addr0, 32'h0);
    end else if (q.size() == 0) begin
      chk("idle_ce", ce0, 32'h1);
      chk("idle_acks", {bus0.if_ack, bus0.d_ack}, 32'h0);
      chk("idle_if_rdata", bus0.if_rdata, held_ir);
      chk("idle_d_rdata", bus0.d_rdata, held_dr);
      schedule();
    end else begin
      e = q.pop_front();
      chk("ce", ce0, e.ce);
      if (!e.ce) begin
        chk("addr", addr0, e.a);
        chk("wre", wre0, e.wen);
        chk("oute", oe0, e.oen);
        chk("masks", {hb0, lb0}, {e.hb, e.lb});
        if (!e.wen) chk("wbus", data0, e.wd);
      end
      chk("if_ack", bus0.if_ack, e.ia);
      chk("d_ack", bus0.d_ack, e.da);
      chk("if_rdata", bus0.if_rdata, e.ir);
      chk("d_rdata", bus0.d_rdata, e.dr);
      if (e.done) act = 0;
    end
  end

  task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, input bit drop, input bit keep, output int lat);
    bit got;
    got = 0;
    lat = 0;
    if (p) begin
      bus0.d_req = 1; bus0.d_we = we; bus0.d_addr = a; bus0.d_wdata = wd; bus0.d_be = be;
    end else begin
      bus0.if_req = 1; bus0.if_addr = a;
    end
    for (int n = 1; n <= 60 && !got; n++) begin
      @(posedge clock); #1;
      if (p ? bus0.d_ack : bus0.if_ack) begin
        got = 1; lat = n;
      end else if (drop && act && act_port == p) begin
        if (p) bus0.d_req = 0; else bus0.if_req = 0;
      end
    end
    chk(p ? "d_ack_seen" : "if_ack_seen", {31'd0, got}, 32'd1);
    if (!keep) begin
      if (p) bus0.d_req = 0; else bus0.if_req = 0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int    lat, oec, ackc;
    bit    got;
    string ord;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'($urandom());
      ref_mem[i] = sram[i];
    end
    sram[2] = 16'h5678; ref_mem[2] = 16'h5678;
    sram[3] = 16'h1234; ref_mem[3] = 16'h1234;
    bus0.if_req = 0; bus0.if_addr = '0; bus0.d_req = 0; bus0.d_we = 0;
    bus0.d_addr = '0; bus0.d_wdata = '0; bus0.d_be = '0;
    bus1.if_req = 0; bus1.if_addr = '0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = '0; bus1.d_wdata = '0; bus1.d_be = '0;
    #1 rst_n = 0; rst2_n = 0;

    // both ports request straight out of reset: data must win first, then alternate
    bus0.if_req = 1; bus0.if_addr = 32'h40;
    bus0.d_req = 1; bus0.d_we = 0; bus0.d_addr = 32'h80; bus0.d_be = 4'hF;
    repeat (3) @(negedge clock);
    @(posedge clock); #1 rst_n = 1; rst2_n = 1;
    ord = "";
    for (int n = 0; n < 40 && ord.len() < 4; n++) begin
      @(posedge clock); #1;
      if (bus0.d_ack)  ord = {ord, "D"};
      if (bus0.if_ack) ord = {ord, "F"};
    end
    n_cmp++;
    if (ord != "DFDF") begin
      n_bad++;
      $display("FAIL grant_order: got %s expected DFDF", ord);
    end
    bus0.if_req = 0; bus0.d_req = 0;

    @(posedge clock); #1;
    txn(0, 0, 32'h4, 32'h0, 4'hF, 0, 0, lat);
    chk("t2_lat", lat, 3);
    chk("t2_rdata", bus0.if_rdata, 32'h12345678);

    @(posedge clock); #1;
    txn(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, lat);
    chk("t3_lat", lat, 3);
    chk("t3_ram8", sram[8], 32'hBEEF);
    chk("t3_ram9", sram[9], 32'hDEAD);

    @(posedge clock); #1;
    txn(1, 1, 32'h10, 32'h00AB0000, 4'b0100, 0, 0, lat);
    chk("t4_lat", lat, 2);
    chk("t4_ram9", sram[9], 32'hDEAB);

    @(posedge clock); #1;
    txn(1, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, 0, 0, lat);
    chk("be0_lat", lat, 1);
    chk("be0_ram8", sram[8], 32'hBEEF);

    @(posedge clock); #1;
    txn(1, 0, 32'hFFF80013, 32'h0, 4'hF, 0, 0, lat);
    chk("hiaddr_rdata", bus0.d_rdata, 32'hDEABBEEF);

    fork
      begin
        int l1;
        bit k1;
        for (int i = 0; i < 150; i++) begin
          k1 = ($urandom_range(0, 3) == 0);
          txn(0, 0, $urandom() & 32'hFFF8007F, 32'h0, 4'hF, $urandom_range(0, 4) == 0, k1, l1);
          if (!k1) repeat ($urandom_range(0, 3)) @(posedge clock);
        end
      end
      begin
        int l2;
        bit k2;
        for (int i = 0; i < 150; i++) begin
          k2 = ($urandom_range(0, 3) == 0);
          txn(1, $urandom_range(0, 1) == 1, $urandom() & 32'hFFF8007F, $urandom(),
              4'($urandom_range(0, 15)), $urandom_range(0, 4) == 0, k2, l2);
          if (!k2) repeat ($urandom_range(0, 3)) @(posedge clock);
        end
      end
    join
    bus0.if_req = 0; bus0.d_req = 0;
    repeat (8) @(posedge clock);

    // WAIT_CYCLES=2: three cycles per half
    @(posedge clock); #1;
    bus1.if_req = 1; bus1.if_addr = 32'h20;
    lat = 0; oec = 0; got = 0;
    for (int n = 1; n <= 30 && !got; n++) begin
      @(posedge clock); #1;
      if (!oe1) oec++;
      if (bus1.if_ack) begin got = 1; lat = n; end
    end
    bus1.if_req = 0;
    chk("w2_lat", lat, 7);
    chk("w2_oe_cycles", oec, 6);
    chk("w2_rdata", bus1.if_rdata, 32'h5A4B5A4A);

    // reset in the HI phase kills the transaction
    @(posedge clock); #1;
    bus1.if_req = 1; bus1.if_addr = 32'h20;
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clock); #1;
      if (!ce1 && addr1[0]) got = 1;
    end
    bus1.if_req = 0;
    chk("w2_hi_reached", {31'd0, got}, 32'd1);
    #2 rst2_n = 0;
    #1;
    chk("w2_rst_strobes", {ce1, wre1, oe1, hb1, lb1}, 32'h1F);
    chk("w2_rst_rdata", bus1.if_rdata, 32'h0);
    @(posedge clock); #1 rst2_n = 1;
    ackc = 0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clock); #1;
      if (bus1.if_ack || bus1.d_ack) ackc++;
    end
    chk("w2_no_ack", ackc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
